temporal_encoder_scheduler: RTL and testbench

Round-robin scheduler that shares one temporal (race-logic) output encoder among `NUM_REQ` requesters. It accepts one value per grant and drives the encoder load port. It then holds the encoder for a full encoding window of `MAX_VALUE+1` cycles, plus `GAP` idle cycles, before granting again. It sits between the neuron/column outputs and the single encoder instance that serialises their counts onto the spike line.

---
 rtl/temporal_encoder_scheduler.sv | 159 +++++++++++++++
 tb/tb_temporal_encoder_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temporal_encoder_scheduler.sv
// rtl/temporal_encoder_scheduler.sv - round-robin scheduler sharing one temporal encoder
// Grants one requester per window; the encoder stays owned for MAX_VALUE+1 cycles plus GAP idle cycles.
module temporal_encoder_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_VALUE = 8,
  parameter int GAP       = 1,
  localparam int VW = $clog2(MAX_VALUE + 1),
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [NUM_REQ*VW-1:0] i_req_value,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic                  i_flush,
  output logic [VW-1:0]         o_enc_line,
  output logic                  o_enc_line_valid,
  output logic                  o_window_active,
  output logic [IW-1:0]         o_window_owner,
  output logic                  o_window_done,
  output logic                  o_clamp_flag
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [VW-1:0] MAXV     = VW'(MAX_VALUE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_GAP
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [VW-1:0]  r_cnt;
  logic [VW-1:0]  w_cnt_nxt;
  logic [GW-1:0]  r_gap_cnt;
  logic [GW-1:0]  w_gap_nxt;
  logic [IW-1:0]  r_last_grant;
  logic [IW-1:0]  r_owner;
  logic [VW-1:0]  r_enc_line;
  logic           r_enc_line_valid;
  logic           r_clamp_flag;

  logic           w_any_valid;
  logic [IW-1:0]  w_winner;
  logic [VW-1:0]  w_win_value;
  logic           w_clamp;
  logic [VW-1:0]  w_load_value;
  logic           w_accept;
  logic           w_done;

  assign w_any_valid = |i_req_valid;

  // Walk downward so the closest requester after last_grant is the final (winning) assignment.
  always_comb begin
    w_winner = r_last_grant;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (i_req_valid[IW'((int'(r_last_grant) + k) % NUM_REQ)]) begin
        w_winner = IW'((int'(r_last_grant) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_win_value = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IW'(i)) begin
        w_win_value = i_req_value[i*VW +: VW];
      end
    end
  end

  assign w_clamp      = (w_win_value > MAXV);
  assign w_load_value = w_clamp ? MAXV : w_win_value;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end
      S_RUN: begin
        if (r_cnt == MAXV) begin
          w_done      = 1'b1;
          w_state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
          w_gap_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + VW'(1);
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt + GW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort keeps last_grant untouched, so the flushed owner stays at lowest priority.
    if (i_flush && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_done      = 1'b0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_gap_cnt        <= '0;
      r_last_grant     <= IW'(NUM_REQ - 1);
      r_owner          <= '0;
      r_enc_line       <= '0;
      r_enc_line_valid <= 1'b0;
      r_clamp_flag     <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      r_gap_cnt        <= w_gap_nxt;
      r_enc_line_valid <= w_accept;
      r_clamp_flag     <= w_accept & w_clamp;
      if (w_accept) begin
        r_enc_line   <= w_load_value;
        r_last_grant <= w_winner;
        r_owner      <= w_winner;
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (w_accept) begin
      o_req_ready[w_winner] = 1'b1;
    end
  end

  assign o_enc_line       = r_enc_line;
  assign o_enc_line_valid = r_enc_line_valid;
  assign o_clamp_flag     = r_clamp_flag;
  assign o_window_owner   = r_owner;
  assign o_window_done    = w_done;
  assign o_window_active  = (r_state == S_LOAD) || (r_state == S_RUN);

endmodule

// File: tb/tb_temporal_encoder_scheduler.sv
// tb/tb_temporal_encoder_scheduler.sv - self-checking bench for temporal_encoder_scheduler
// Instance 0 uses GAP=1, instance 1 uses GAP=0; both see identical stimulus.
module tb_temporal_encoder_scheduler;

  localparam int NR   = 4;
  localparam int MAXV = 8;
  localparam int VW   = 4;
  localparam int IW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    valid = '0;
  logic [NR*VW-1:0] value = '0;
  logic             flush = 1'b0;

  logic [NR-1:0] rdy  [2];
  logic [VW-1:0] line [2];
  logic          elv  [2];
  logic          act  [2];
  logic [IW-1:0] own  [2];
  logic          done [2];
  logic          clmp [2];

  temporal_encoder_scheduler #(.NUM_REQ(NR), .MAX_VALUE(MAXV), .GAP(1)) dut (
    .i_clock(clk), .i_reset(rst), .i_req_valid(valid), .i_req_value(value),
    .o_req_ready(rdy[0]), .i_flush(flush), .o_enc_line(line[0]),
    .o_enc_line_valid(elv[0]), .o_window_active(act[0]), .o_window_owner(own[0]),
    .o_window_done(done[0]), .o_clamp_flag(clmp[0])
  );

  temporal_encoder_scheduler #(.NUM_REQ(NR), .MAX_VALUE(MAXV), .GAP(0)) dut_g0 (
    .i_clock(clk), .i_reset(rst), .i_req_valid(valid), .i_req_value(value),
    .o_req_ready(rdy[1]), .i_flush(flush), .o_enc_line(line[1]),
    .o_enc_line_valid(elv[1]), .o_window_active(act[1]), .o_window_owner(own[1]),
    .o_window_done(done[1]), .o_clamp_flag(clmp[1])
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    valid = '0;
    value = '0;
    flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      if (c > 0) tick();
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({rdy[d], line[d], elv[d], act[d], own[d], done[d], clmp[d]} !== '0) begin
          failures++;
          $display("FAIL reset_idle dut%0d cyc%0d: ready=%b line=%0d elv=%b act=%b own=%0d done=%b clamp=%b, all required 0",
                   d, c, rdy[d], line[d], elv[d], act[d], own[d], done[d], clmp[d]);
        end
      end
    end
  endtask

  task automatic test_single_grant();
    apply_reset();
    valid = 4'b0100;
    value[2*VW +: VW] = 4'd5;
    #1;
    checks++;
    if (rdy[0] !== 4'b0100) begin
      failures++;
      $display("FAIL single_ready: got %b, required 0100", rdy[0]);
    end
    for (int t = 1; t <= 12; t++) begin
      tick();
      valid = (t >= 11) ? 4'b0001 : 4'b0000;
      #1;
      if (t == 1) begin
        checks++;
        if (elv[0] !== 1'b1 || line[0] !== 4'd5) begin
          failures++;
          $display("FAIL single_load: elv=%b line=%0d, required 1 and 5", elv[0], line[0]);
        end
      end
      checks++;
      if (done[0] !== (t == 10)) begin
        failures++;
        $display("FAIL single_done t=%0d: got %b, required %b", t, done[0], (t == 10));
      end
      if (t <= 11) begin
        checks++;
        if (own[0] !== 2'd2) begin
          failures++;
          $display("FAIL single_owner t=%0d: got %0d, required 2", t, own[0]);
        end
      end
      if (t == 11) begin
        checks++;
        if (rdy[0] !== 4'b0000 || rdy[1] !== 4'b0001) begin
          failures++;
          $display("FAIL single_gap_cycle: ready gap1=%b gap0=%b, required 0000 and 0001", rdy[0], rdy[1]);
        end
      end
      if (t == 12) begin
        checks++;
        if (rdy[0] !== 4'b0001) begin
          failures++;
          $display("FAIL single_idle_again: ready=%b, required 0001", rdy[0]);
        end
      end
    end
    valid = '0;
  endtask

  task automatic test_fairness();
    logic [NR-1:0] e0, e1;
    apply_reset();
    valid = 4'b1111;
    value = 16'($urandom());
    for (int c = 0; c < 48; c++) begin
      if (c > 0) tick();
      #1;
      e0 = (c % 12 == 0) ? NR'(1 << (c / 12)) : '0;
      e1 = (c % 11 == 0) ? NR'(1 << ((c / 11) % NR)) : '0;
      checks++;
      if (rdy[0] !== e0) begin
        failures++;
        $display("FAIL fair_gap1 c=%0d: ready=%b, required %b", c, rdy[0], e0);
      end
      checks++;
      if (rdy[1] !== e1) begin
        failures++;
        $display("FAIL fair_gap0 c=%0d: ready=%b, required %b", c, rdy[1], e1);
      end
    end
    valid = '0;
  endtask

  task automatic test_clamp();
    apply_reset();
    valid = 4'b0010;
    value[1*VW +: VW] = 4'd13;
    #1;
    checks++;
    if (rdy[0] !== 4'b0010) begin
      failures++;
      $display("FAIL clamp_ready: got %b, required 0010", rdy[0]);
    end
    for (int t = 1; t <= 10; t++) begin
      tick();
      valid = '0;
      #1;
      if (t == 1) begin
        checks++;
        if (line[0] !== 4'd8 || clmp[0] !== 1'b1 || elv[0] !== 1'b1) begin
          failures++;
          $display("FAIL clamp_load: line=%0d clamp=%b elv=%b, required 8 1 1", line[0], clmp[0], elv[0]);
        end
      end
      if (t == 2) begin
        checks++;
        if (line[0] !== 4'd8 || clmp[0] !== 1'b0 || elv[0] !== 1'b0 || act[0] !== 1'b1) begin
          failures++;
          $display("FAIL clamp_run: line=%0d clamp=%b elv=%b act=%b, required 8 0 0 1", line[0], clmp[0], elv[0], act[0]);
        end
      end
      if (t == 10) begin
        checks++;
        if (done[0] !== 1'b1) begin
          failures++;
          $display("FAIL clamp_done: got %b, required 1", done[0]);
        end
      end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    valid = 4'b0010;
    value[1*VW +: VW] = 4'd3;
    #1;
    checks++;
    if (rdy[0] !== 4'b0010) begin
      failures++;
      $display("FAIL flush_grant1: ready=%b, required 0010", rdy[0]);
    end
    for (int t = 1; t <= 14; t++) begin
      tick();
      valid = (t <= 5) ? 4'b1010 : 4'b0000;
      flush = (t == 4);
      #1;
      if (t == 4) begin
        checks++;
        if (act[0] !== 1'b1 || done[0] !== 1'b0) begin
          failures++;
          $display("FAIL flush_cycle: act=%b done=%b, required 1 0", act[0], done[0]);
        end
      end
      if (t == 5) begin
        checks++;
        if (rdy[0] !== 4'b1000 || rdy[1] !== 4'b1000 || elv[0] !== 1'b0 || act[0] !== 1'b0) begin
          failures++;
          $display("FAIL flush_next_grant: ready=%b/%b elv=%b act=%b, required 1000/1000 0 0", rdy[0], rdy[1], elv[0], act[0]);
        end
      end
      if (t >= 5) begin
        checks++;
        if (done[0] !== 1'b0) begin
          failures++;
          $display("FAIL flush_no_done t=%0d: got %b, required 0", t, done[0]);
        end
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    valid = 4'b0001;
    #1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      valid = '0;
      #1;
    end
    checks++;
    if (act[0] !== 1'b1) begin
      failures++;
      $display("FAIL midrun_active: got %b, required 1", act[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (act[0] !== 1'b0 || act[1] !== 1'b0) begin
      failures++;
      $display("FAIL midrun_async_clear: act=%b/%b, required 0/0", act[0], act[1]);
    end
    tick();
    rst = 1'b0;
    for (int t = 0; t < 15; t++) begin
      tick();
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({done[d], elv[d], act[d], clmp[d], rdy[d]} !== '0) begin
          failures++;
          $display("FAIL midrun_quiet dut%0d t=%0d: done=%b elv=%b act=%b clamp=%b ready=%b, required all 0",
                   d, t, done[d], elv[d], act[d], clmp[d], rdy[d]);
        end
      end
    end
  endtask

  // Timeline model: each grant at cycle g owns LOAD at g+1, RUN g+2..g+2+MAX, next accept at g+3+MAX+gap.
  task automatic test_random();
    int m_last [2];
    int m_grant[2];
    int m_free [2];
    int m_val  [2];
    int m_pval [2];
    int m_own  [2];
    int m_pown [2];
    bit m_clamp[2];
    int gapv   [2];
    gapv[0] = 1;
    gapv[1] = 0;
    apply_reset();
    for (int d = 0; d < 2; d++) begin
      m_last[d] = NR - 1; m_grant[d] = -1; m_free[d] = cyc;
      m_val[d] = 0; m_pval[d] = 0; m_own[d] = 0; m_pown[d] = 0; m_clamp[d] = 1'b0;
    end
    for (int n = 0; n < 800; n++) begin
      if (n > 0) tick();
      valid = NR'($urandom_range(0, 15));
      value = 16'($urandom());
      flush = ($urandom_range(0, 19) == 0);
      #1;
      for (int d = 0; d < 2; d++) begin
        int t, win, v, eline, eown;
        bit idle, live, eact, eelv, eclmp, edone;
        logic [NR-1:0] erdy;
        idle = (cyc >= m_free[d]);
        live = !idle && (m_grant[d] >= 0);
        t    = cyc - m_grant[d];
        win  = -1;
        erdy = '0;
        if (idle) begin
          for (int k = 1; k <= NR; k++) begin
            if (win < 0 && valid[(m_last[d] + k) % NR]) win = (m_last[d] + k) % NR;
          end
          if (win >= 0) erdy = NR'(1 << win);
        end
        eact  = live && t >= 1 && t <= 2 + MAXV;
        eelv  = live && t == 1;
        eclmp = eelv && m_clamp[d];
        edone = live && t == 2 + MAXV && !flush;
        eline = (m_grant[d] >= 0 && cyc > m_grant[d]) ? m_val[d] : m_pval[d];
        eown  = (m_grant[d] >= 0 && cyc > m_grant[d]) ? m_own[d] : m_pown[d];
        checks++;
        if (rdy[d] !== erdy || act[d] !== eact || elv[d] !== eelv || clmp[d] !== eclmp || done[d] !== edone) begin
          failures++;
          $display("FAIL rand_ctrl dut%0d cyc%0d: ready=%b act=%b elv=%b clamp=%b done=%b, required %b %b %b %b %b",
                   d, cyc, rdy[d], act[d], elv[d], clmp[d], done[d], erdy, eact, eelv, eclmp, edone);
        end
        checks++;
        if (int'(line[d]) != eline || int'(own[d]) != eown) begin
          failures++;
          $display("FAIL rand_data dut%0d cyc%0d: line=%0d owner=%0d, required %0d %0d", d, cyc, line[d], own[d], eline, eown);
        end
        if (win >= 0) begin
          v = int'(value[win*VW +: VW]);
          m_pval[d]  = m_val[d];
          m_pown[d]  = m_own[d];
          m_val[d]   = (v > MAXV) ? MAXV : v;
          m_clamp[d] = (v > MAXV);
          m_own[d]   = win;
          m_last[d]  = win;
          m_grant[d] = cyc;
          m_free[d]  = cyc + 3 + MAXV + gapv[d];
        end else if (flush && !idle) begin
          m_free[d] = cyc + 1;
        end
      end
    end
    flush = 1'b0;
    valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_fairness();
    test_clamp();
    test_flush();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
